// File: rtl/dsp38_mac_sequencer.sv
// Sequences a DSP38 in MULTIPLY_ACCUMULATE mode as an N-term dot-product engine.
// Optional define DSP38_MAC_SEQ_ROUND_EN adds per-packet cfg_round/cfg_shift_right inputs.
module dsp38_mac_sequencer #(
   parameter int MAX_TERMS   = 64,
   parameter int DSP_LATENCY = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [19:0] in_a,
   input  logic [17:0] in_b,
   input  logic        in_last,
   input  logic        in_sub,
   input  logic        cfg_unsigned_a,
   input  logic        cfg_unsigned_b,
`ifdef DSP38_MAC_SEQ_ROUND_EN
   input  logic        cfg_round,
   input  logic [5:0]  cfg_shift_right,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [37:0] out_z,
   output logic [6:0]  out_terms,
   output logic        out_err,
   output logic [19:0] dsp_a,
   output logic [17:0] dsp_b,
   output logic        dsp_load_acc,
   output logic [2:0]  dsp_feedback,
   output logic        dsp_subtract,
   output logic        dsp_unsigned_a,
   output logic        dsp_unsigned_b,
   output logic        dsp_round,
   output logic [5:0]  dsp_shift_right,
   output logic        dsp_saturate,
   input  logic [37:0] dsp_z
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

   localparam int              LAT_W   = (DSP_LATENCY < 2) ? 1 : $clog2(DSP_LATENCY + 1);
   localparam logic [LAT_W-1:0] LAT_END = LAT_W'(DSP_LATENCY);
   localparam logic [6:0]       MAX_CNT = 7'(MAX_TERMS);

   state_t           state;
   logic [6:0]       term_cnt;
   logic             err;
   logic [LAT_W-1:0] lat_cnt;

   logic       beat;
   logic [6:0] next_cnt;
   logic       hit_max;
   logic       is_last;

   assign dsp_saturate = 1'b0;

   // A beat that reaches MAX_TERMS closes the packet even without in_last.
   always_comb begin
      beat     = in_valid & in_ready;
      next_cnt = (state == IDLE) ? 7'd1 : term_cnt + 7'd1;
      hit_max  = (next_cnt == MAX_CNT);
      is_last  = in_last | hit_max;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state           <= IDLE;
         in_ready        <= 1'b0;
         term_cnt        <= 7'd0;
         err             <= 1'b0;
         lat_cnt         <= '0;
         out_valid       <= 1'b0;
         out_z           <= 38'd0;
         out_terms       <= 7'd0;
         out_err         <= 1'b0;
         dsp_a           <= 20'd0;
         dsp_b           <= 18'd0;
         dsp_load_acc    <= 1'b0;
         dsp_feedback    <= 3'd0;
         dsp_subtract    <= 1'b0;
         dsp_unsigned_a  <= 1'b1;
         dsp_unsigned_b  <= 1'b1;
         dsp_round       <= 1'b0;
         dsp_shift_right <= 6'd0;
      end else begin
         dsp_load_acc <= 1'b0;
         case (state)
            IDLE, ACCUM: begin
               in_ready <= 1'b1;
               if (beat) begin
                  dsp_a        <= in_a;
                  dsp_b        <= in_b;
                  dsp_subtract <= in_sub;
                  dsp_load_acc <= 1'b1;
                  term_cnt     <= next_cnt;
                  // Feedback 1 on the first beat discards whatever the DSP accumulator held.
                  if (state == IDLE) begin
                     dsp_feedback   <= 3'd1;
                     dsp_unsigned_a <= cfg_unsigned_a;
                     dsp_unsigned_b <= cfg_unsigned_b;
`ifdef DSP38_MAC_SEQ_ROUND_EN
                     dsp_round       <= cfg_round;
                     dsp_shift_right <= cfg_shift_right;
`endif
                  end else begin
                     dsp_feedback <= 3'd0;
                  end
                  if (is_last) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                     lat_cnt  <= '0;
                     err      <= hit_max & ~in_last;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            DRAIN: begin
               if (lat_cnt == LAT_END) begin
                  out_z     <= dsp_z;
                  out_terms <= term_cnt;
                  out_err   <= err;
                  out_valid <= 1'b1;
                  state     <= RESULT;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            RESULT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Randomized bench for dsp38_mac_sequencer with a behavioural DSP38 accumulator on dsp_z
// and a dot-product reference model computed from the stimulus that was sent.
module tb_dsp38_mac_sequencer;

   localparam int MAX_T = 6;
   localparam int LAT   = 1;

   logic        CLK;
   logic        RESET;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_a;
   logic [17:0] in_b;
   logic        in_last;
   logic        in_sub;
   logic        cfg_unsigned_a;
   logic        cfg_unsigned_b;
`ifdef DSP38_MAC_SEQ_ROUND_EN
   logic        cfg_round;
   logic [5:0]  cfg_shift_right;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [37:0] out_z;
   logic [6:0]  out_terms;
   logic        out_err;
   logic [19:0] dsp_a;
   logic [17:0] dsp_b;
   logic        dsp_load_acc;
   logic [2:0]  dsp_feedback;
   logic        dsp_subtract;
   logic        dsp_unsigned_a;
   logic        dsp_unsigned_b;
   logic        dsp_round;
   logic [5:0]  dsp_shift_right;
   logic        dsp_saturate;
   logic [37:0] dsp_z;

   int tests_run;
   int tests_failed;

   logic [19:0] q_a[$];
   logic [17:0] q_b[$];
   logic        q_sub[$];
   logic        q_ua;
   logic        q_ub;

   dsp38_mac_sequencer #(.MAX_TERMS(MAX_T), .DSP_LATENCY(LAT)) dut (
      .CLK(CLK), .RESET(RESET),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .in_sub(in_sub),
      .cfg_unsigned_a(cfg_unsigned_a), .cfg_unsigned_b(cfg_unsigned_b),
`ifdef DSP38_MAC_SEQ_ROUND_EN
      .cfg_round(cfg_round), .cfg_shift_right(cfg_shift_right),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
      .out_terms(out_terms), .out_err(out_err),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_load_acc(dsp_load_acc),
      .dsp_feedback(dsp_feedback), .dsp_subtract(dsp_subtract),
      .dsp_unsigned_a(dsp_unsigned_a), .dsp_unsigned_b(dsp_unsigned_b),
      .dsp_round(dsp_round), .dsp_shift_right(dsp_shift_right),
      .dsp_saturate(dsp_saturate), .dsp_z(dsp_z)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic longint product(input logic [19:0] a, input logic [17:0] b,
                                      input logic ua, input logic ub);
      longint av;
      longint bv;
      av = ua ? longint'({44'd0, a}) : longint'($signed(a));
      bv = ub ? longint'({46'd0, b}) : longint'($signed(b));
      return av * bv;
   endfunction

   // DSP38 stand-in: one edge from drive registers to Z, accumulator never cleared by reset.
   logic [37:0] dsp_acc = 38'h15A5A5A5A5;
   longint      dsp_term;
   always_comb begin
      dsp_term = product(dsp_a, dsp_b, dsp_unsigned_a, dsp_unsigned_b);
      if (dsp_subtract) dsp_term = -dsp_term;
   end
   always @(posedge CLK) begin
      if (dsp_load_acc)
         dsp_acc <= ((dsp_feedback == 3'd1) ? 38'd0 : dsp_acc) + dsp_term[37:0];
   end
   assign dsp_z = dsp_acc;

   function automatic logic [37:0] ref_dot();
      longint acc;
      longint p;
      acc = 0;
      for (int i = 0; i < q_a.size() && i < MAX_T; i++) begin
         p   = product(q_a[i], q_b[i], q_ua, q_ub);
         acc = q_sub[i] ? acc - p : acc + p;
      end
      return acc[37:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_packet(input logic ua, input logic ub);
      q_a.delete();
      q_b.delete();
      q_sub.delete();
      q_ua = ua;
      q_ub = ub;
   endtask

   // Presents one beat and returns #1 after the edge that accepted it; in_valid is left high.
   task automatic applyStimulus(input logic [19:0] a, input logic [17:0] b, input logic sub,
                                input logic last, input logic ua, input logic ub);
      logic seen;
      int   n;
      in_a = a; in_b = b; in_sub = sub; in_last = last;
      cfg_unsigned_a = ua; cfg_unsigned_b = ub;
      in_valid = 1'b1;
      n = 0;
      do begin
         seen = in_ready;
         tick();
         n++;
      end while (!seen && n < 100);
      if (!seen) begin
         checkOutput("accept_timeout", 64'd0, 64'd1);
         return;
      end
      q_a.push_back(a);
      q_b.push_back(b);
      q_sub.push_back(sub);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_result(input string tag, input logic [37:0] exp_z, input int exp_terms,
                              input logic exp_err, input int hold);
      int n;
      n = 0;
      out_ready = 1'b0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
         return;
      end
      checkOutput({tag, "_z"}, out_z, exp_z);
      checkOutput({tag, "_terms"}, out_terms, exp_terms);
      checkOutput({tag, "_err"}, out_err, exp_err);
      for (int i = 0; i < hold; i++) begin
         tick();
         checkOutput({tag, "_hold_valid"}, out_valid, 1'b1);
         checkOutput({tag, "_hold_z"}, out_z, exp_z);
         checkOutput({tag, "_hold_in_ready"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, out_valid, 1'b0);
      checkOutput({tag, "_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [19:0] pa[4];
      logic [17:0] pb[4];
      int          len;
      logic        trunc;
      logic        ua;
      logic        ub;

      tests_run = 0;
      tests_failed = 0;
      RESET = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_sub = 1'b0;
      cfg_unsigned_a = 1'b0; cfg_unsigned_b = 1'b0; out_ready = 1'b0;
`ifdef DSP38_MAC_SEQ_ROUND_EN
      cfg_round = 1'b0; cfg_shift_right = 6'd0;
`endif

      // Reset held for two cycles: every output at its reset value.
      tick();
      tick();
      checkOutput("rst_in_ready", in_ready, 1'b0);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_z", out_z, 38'd0);
      checkOutput("rst_out_terms", out_terms, 7'd0);
      checkOutput("rst_out_err", out_err, 1'b0);
      checkOutput("rst_load_acc", dsp_load_acc, 1'b0);
      checkOutput("rst_feedback", dsp_feedback, 3'd0);
      checkOutput("rst_dsp_a", dsp_a, 20'd0);
      checkOutput("rst_dsp_b", dsp_b, 18'd0);
      checkOutput("rst_subtract", dsp_subtract, 1'b0);
      checkOutput("rst_unsigned", {dsp_unsigned_a, dsp_unsigned_b}, 2'b11);
      checkOutput("rst_round", {dsp_round, dsp_shift_right}, 7'd0);
      checkOutput("rst_saturate", dsp_saturate, 1'b0);
      RESET = 1'b0;
      tick();
      checkOutput("post_rst_in_ready", in_ready, 1'b1);

      // Back-to-back four-beat unsigned packet with result timing and a stalled consumer.
      pa[0] = 20'd20; pa[1] = 20'd40; pa[2] = 20'd60; pa[3] = 20'd80;
      pb[0] = 18'd3;  pb[1] = 18'd5;  pb[2] = 18'd7;  pb[3] = 18'd9;
      clear_packet(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(pa[i], pb[i], 1'b0, i == 3, 1'b1, 1'b1);
         checkOutput("p2_feedback", dsp_feedback, (i == 0) ? 3'd1 : 3'd0);
         checkOutput("p2_load_acc", dsp_load_acc, 1'b1);
         checkOutput("p2_dsp_a", dsp_a, pa[i]);
         checkOutput("p2_dsp_b", dsp_b, pb[i]);
      end
      in_valid = 1'b0;
      checkOutput("p2_valid_e0", out_valid, 1'b0);
      checkOutput("p2_in_ready_drain", in_ready, 1'b0);
      tick();
      checkOutput("p2_valid_e1", out_valid, 1'b0);
      tick();
      checkOutput("p2_valid_e2", out_valid, 1'b1);
      wait_result("p2", ref_dot(), 4, 1'b0, 10);

      // Same operands with 3-cycle gaps and a subtracted second product.
      clear_packet(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(pa[i], pb[i], i == 1, i == 3, 1'b1, 1'b1);
         checkOutput("p3_subtract", dsp_subtract, i == 1);
         if (i < 3) begin
            in_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
               tick();
               checkOutput("p3_gap_load_acc", dsp_load_acc, 1'b0);
            end
         end
      end
      in_valid = 1'b0;
      wait_result("p3", ref_dot(), 4, 1'b0, 0);

      // No in_last: the MAX_T-th beat is forced last, the following beats form a new packet.
      clear_packet(1'b1, 1'b1);
      for (int i = 0; i < MAX_T; i++) applyStimulus(20'd1, 18'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      in_a = 20'd1; in_b = 18'd1; in_last = 1'b0; in_valid = 1'b1;
      wait_result("p4a", 38'(MAX_T), MAX_T, 1'b1, 2);
      clear_packet(1'b1, 1'b1);
      applyStimulus(20'd1, 18'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("p4b_feedback", dsp_feedback, 3'd1);
      applyStimulus(20'd1, 18'd1, 1'b0, 1'b1, 1'b1, 1'b1);
      in_valid = 1'b0;
      wait_result("p4b", 38'd2, 2, 1'b0, 0);

      // Reset mid-packet; the next packet must not see the stale accumulator.
      clear_packet(1'b0, 1'b0);
      applyStimulus(20'hFFFFF, 18'h1FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(20'h12345, 18'h0ABCD, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      RESET = 1'b1;
      tick();
      checkOutput("p6_rst_in_ready", in_ready, 1'b0);
      checkOutput("p6_rst_load_acc", dsp_load_acc, 1'b0);
      RESET = 1'b0;
      tick();
      clear_packet(1'b1, 1'b1);
      applyStimulus(20'd2, 18'd2, 1'b0, 1'b1, 1'b1, 1'b1);
      in_valid = 1'b0;
      wait_result("p6", 38'd4, 1, 1'b0, 0);

      // Random packets: lengths, signedness, subtracts, gaps and consumer delays.
      for (int p = 0; p < 30; p++) begin
         len   = $urandom_range(1, MAX_T);
         trunc = (len == MAX_T) && ($urandom_range(0, 1) == 1);
         ua    = 1'($urandom_range(0, 1));
         ub    = 1'($urandom_range(0, 1));
         clear_packet(ua, ub);
         for (int i = 0; i < len; i++) begin
            applyStimulus(20'($urandom), 18'($urandom), 1'($urandom_range(0, 1)),
                          (i == len - 1) && !trunc,
                          (i == 0) ? ua : 1'($urandom_range(0, 1)),
                          (i == 0) ? ub : 1'($urandom_range(0, 1)));
            if (i < len - 1) idle($urandom_range(0, 2));
         end
         in_valid = 1'b0;
         in_last  = 1'($urandom_range(0, 1));
         wait_result("rnd", ref_dot(), len, trunc, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
